arb_mux: RTL

Parametrised N-input arbitrating multiplexer with valid/ready handshakes and a registered output. It is the successor to the combinational 4:1 select mux. The block picks one requesting input per cycle, either round-robin or fixed priority, and holds the selected word in an output register until the downstream consumer accepts it. It sits wherever several producers share one datapath, for example display/LED drivers or UART TX fed from multiple sources.

---
 rtl/arb_mux.sv | 87 ++++++++
 1 files changed

// File: rtl/arb_mux.sv
// N-input arbitrating multiplexer with a registered, handshaked output.
// Round-robin or fixed-priority grant; one word per cycle when unstalled.
module arb_mux #(
    parameter  int IN_WIDTH  = 8,
    parameter  int N_IN      = 4,
    localparam int SEL_WIDTH = $clog2(N_IN)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_IN-1:0][IN_WIDTH-1:0] in,
    input  logic [N_IN-1:0]               in_valid,
    output logic [N_IN-1:0]               in_ready,
    input  logic                          prio_mode,
    output logic [IN_WIDTH-1:0]           out,
    output logic [SEL_WIDTH-1:0]          out_sel,
    output logic                          out_valid,
    input  logic                          out_ready
);

    logic [IN_WIDTH-1:0]  out_q;
    logic [SEL_WIDTH-1:0] sel_q;
    logic                 valid_q;
    logic [SEL_WIDTH-1:0] last_q;

    logic                 load_en;
    logic                 any_req;
    logic                 hi_found;
    logic [SEL_WIDTH-1:0] first_any;
    logic [SEL_WIDTH-1:0] first_hi;
    logic [SEL_WIDTH-1:0] win;

    assign load_en = !valid_q || out_ready;
    assign any_req = |in_valid;

    // first_hi: lowest requester above the pointer; first_any: lowest overall
    always_comb begin
        hi_found  = 1'b0;
        first_any = '0;
        first_hi  = '0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                first_any = SEL_WIDTH'(i);
                if (i > int'(last_q)) begin
                    first_hi = SEL_WIDTH'(i);
                    hi_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        win = first_any;
        if (!prio_mode && hi_found) begin
            win = first_hi;
        end
    end

    always_comb begin
        in_ready = '0;
        if (rst_n && load_en && any_req) begin
            in_ready = N_IN'(1) << win;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= SEL_WIDTH'(N_IN - 1);
        end else if (load_en) begin
            if (any_req) begin
                out_q   <= in[win];
                sel_q   <= win;
                valid_q <= 1'b1;
                last_q  <= win;
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign out       = out_q;
    assign out_sel   = sel_q;
    assign out_valid = valid_q;

endmodule
